gbus_wrr_arbiter: RTL and testbench

Weighted round-robin arbiter that shares the single global bus between the per-head-core bus packet FIFOs. It takes the FIFOs' show-ahead head packets and not-empty flags, issues a one-hot pop/grant, and drives one registered bus packet per cycle onto gbus_addr/gbus_wdata/gbus_wen. Each core may hold the bus for a configurable burst of consecutive beats, which keeps multi-word writebacks contiguous without starving other cores.

---
 rtl/gbus_pkg.sv | 26 ++
 rtl/gbus_rr_pick.sv | 45 ++++
 rtl/gbus_wrr_arbiter.sv | 141 ++++++++++++++
 tb/tb_gbus_wrr_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbus_pkg.sv
// Shared widths, bus packet layout and arbiter state encoding for the global bus.
`default_nettype none

package gbus_pkg;

   localparam int BUS_DATA_WIDTH       = 32;
   localparam int BUS_CMEM_ADDR_WIDTH  = 13;
   localparam int BUS_CORE_ADDR_WIDTH  = 4;
   localparam int HEAD_SRAM_BIAS_WIDTH = 2;
   localparam int GBUS_ADDR_WIDTH      = HEAD_SRAM_BIAS_WIDTH + BUS_CORE_ADDR_WIDTH
                                         + BUS_CMEM_ADDR_WIDTH;
   localparam int GBUS_PKT_WIDTH       = BUS_DATA_WIDTH + GBUS_ADDR_WIDTH;

   typedef struct packed {
      logic [BUS_DATA_WIDTH-1:0]  wdata;
      logic [GBUS_ADDR_WIDTH-1:0] addr;
   } gbus_pkt_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/gbus_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after start_i, modulo N.
`default_nettype none

module gbus_rr_pick #(
   parameter int N     = 16,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             vld_o
);

   always_comb begin
      int j;
      logic [IDX_W-1:0] j_idx;
      j      = 0;
      j_idx  = '0;
      idx_o  = '0;
      vld_o  = 1'b0;
      // Walk offsets from farthest to nearest so the nearest requester wins last.
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(start_i) + i;
         if (j >= N) begin
            j = j - N;
         end
         j_idx = IDX_W'(j);
         if (req_i[j_idx]) begin
            vld_o = 1'b1;
            idx_o = j_idx;
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      if (vld_o) begin
         gnt_o[idx_o] = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/gbus_wrr_arbiter.sv
// Weighted round-robin arbiter driving one registered packet per cycle onto the global bus.
// Weighted bursts are enabled by defining GBUS_ARB_WEIGHT_EN; otherwise plain one-beat round robin.
`default_nettype none

module gbus_wrr_arbiter
   import gbus_pkg::*;
#(
   parameter int REQ_NUM      = 16,
   parameter int PKT_WIDTH    = GBUS_PKT_WIDTH,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [REQ_NUM-1:0]              req_array,
   input  logic [REQ_NUM*PKT_WIDTH-1:0]    in_pkt_array,
   input  logic [REQ_NUM*WEIGHT_WIDTH-1:0] cfg_weight_array,
   output logic [REQ_NUM-1:0]              grant_array,
   output logic [PKT_WIDTH-1:0]            bus_packet,
   output logic                            bus_packet_vld,
   output logic                            arb_busy
);

   localparam int IDX_W = $clog2(REQ_NUM);

   arb_state_e              state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [WEIGHT_WIDTH-1:0] burst_left_q, burst_left_d;

   logic [PKT_WIDTH-1:0]    bus_packet_q;
   logic                    bus_packet_vld_q;

   logic [REQ_NUM-1:0]      pick_gnt;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_vld;
   logic                    hold_ok;
   logic [WEIGHT_WIDTH-1:0] w_eff;
   logic [IDX_W-1:0]        gnt_idx;
   logic [PKT_WIDTH-1:0]    pkt_slice [REQ_NUM];

   for (genvar g = 0; g < REQ_NUM; g++) begin : g_pkt_unpack
      assign pkt_slice[g] = in_pkt_array[g*PKT_WIDTH +: PKT_WIDTH];
   end

`ifdef GBUS_ARB_WEIGHT_EN
   logic [WEIGHT_WIDTH-1:0] weight [REQ_NUM];

   for (genvar g = 0; g < REQ_NUM; g++) begin : g_weight_unpack
      assign weight[g] = cfg_weight_array[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   end

   // A zero weight still grants one beat per turn.
   assign w_eff = (weight[pick_idx] == '0) ? WEIGHT_WIDTH'(1) : weight[pick_idx];
`else
   logic unused_cfg_weight;
   assign unused_cfg_weight = ^cfg_weight_array;
   assign w_eff             = WEIGHT_WIDTH'(1);
`endif

   gbus_rr_pick #(
      .N     (REQ_NUM),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (req_array),
      .start_i (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .vld_o   (pick_vld)
   );

   assign hold_ok = (state_q == HOLD) && req_array[owner_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         burst_left_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         burst_left_q <= burst_left_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      burst_left_d = burst_left_q;
      if (hold_ok) begin
         burst_left_d = burst_left_q - WEIGHT_WIDTH'(1);
         if (burst_left_q == WEIGHT_WIDTH'(1)) begin
            state_d = IDLE;
         end
      end else if (pick_vld) begin
         // Fresh turn: also taken in the same cycle a burst owner drops its request.
         rr_ptr_d = (pick_idx == IDX_W'(REQ_NUM - 1)) ? '0 : pick_idx + IDX_W'(1);
         if (w_eff > WEIGHT_WIDTH'(1)) begin
            state_d      = HOLD;
            owner_d      = pick_idx;
            burst_left_d = w_eff - WEIGHT_WIDTH'(1);
         end else begin
            state_d = IDLE;
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_comb begin
      grant_array = '0;
      gnt_idx     = pick_idx;
      if (hold_ok) begin
         grant_array[owner_q] = 1'b1;
         gnt_idx              = owner_q;
      end else begin
         grant_array = pick_gnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_packet_q     <= '0;
         bus_packet_vld_q <= 1'b0;
      end else begin
         bus_packet_vld_q <= |grant_array;
         if (|grant_array) begin
            bus_packet_q <= pkt_slice[gnt_idx];
         end
      end
   end

   assign bus_packet     = bus_packet_q;
   assign bus_packet_vld = bus_packet_vld_q;
   assign arb_busy       = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_gbus_wrr_arbiter.sv
// Directed self-checking bench for gbus_wrr_arbiter; adapts expectations to GBUS_ARB_WEIGHT_EN.
`default_nettype none

module tb_gbus_wrr_arbiter;
   import gbus_pkg::*;

   localparam int N  = 16;
   localparam int PW = GBUS_PKT_WIDTH;
   localparam int WW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*PW-1:0] pkts;
   logic [N*WW-1:0] wts;
   logic [N-1:0]    grant;
   logic [PW-1:0]   bus_pkt;
   logic            vld;
   logic            busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   gbus_wrr_arbiter #(
      .REQ_NUM      (N),
      .PKT_WIDTH    (PW),
      .WEIGHT_WIDTH (WW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_array        (req),
      .in_pkt_array     (pkts),
      .cfg_weight_array (wts),
      .grant_array      (grant),
      .bus_packet       (bus_pkt),
      .bus_packet_vld   (vld),
      .arb_busy         (busy)
   );

   function automatic logic [PW-1:0] pkt_of(input int i);
      gbus_pkt_t p;
      if (i == 0) begin
         p.wdata = 32'hDEADBEEF;
         p.addr  = 19'h00005;
      end else begin
         p.wdata = 32'hC0DE_0000 + 32'(i);
         p.addr  = 19'h00100 + 19'(i);
      end
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_all_weights(input logic [WW-1:0] w);
      for (int i = 0; i < N; i++) wts[i*WW +: WW] = w;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk_cnt++;
      if (vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", vld); else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      chk_cnt++;
      if (bus_pkt !== '0) $display("FAIL reset_pkt: got %h expected 0", bus_pkt); else pass_cnt++;
      chk_cnt++;
      if (grant !== '0) $display("FAIL reset_grant_none: got %h expected 0", grant); else pass_cnt++;
      req = 16'h0004;
      #1;
      chk_cnt++;
      if (grant !== 16'h0004) $display("FAIL reset_grant_comb: got %h expected 0004", grant); else pass_cnt++;
      tick();
      chk_cnt++;
      if (vld !== 1'b0) $display("FAIL reset_held_vld: got %b expected 0", vld); else pass_cnt++;
      req   = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      set_all_weights(4'd1);
      req = 16'h0001;
      #1;
      chk_cnt++;
      if (grant !== 16'h0001) $display("FAIL single_grant: got %h expected 0001", grant); else pass_cnt++;
      tick();
      chk_cnt++;
      if (vld !== 1'b1) $display("FAIL single_vld: got %b expected 1", vld); else pass_cnt++;
      chk_cnt++;
      if (bus_pkt !== {32'hDEADBEEF, 19'h00005})
         $display("FAIL single_pkt: got %h expected %h", bus_pkt, {32'hDEADBEEF, 19'h00005});
      else pass_cnt++;
      req = '0;
      #1;
      chk_cnt++;
      if (grant !== '0) $display("FAIL single_nogrant: got %h expected 0", grant); else pass_cnt++;
      tick();
      chk_cnt++;
      if (vld !== 1'b0) $display("FAIL single_vld_drop: got %b expected 0", vld); else pass_cnt++;
      chk_cnt++;
      if (bus_pkt !== pkt_of(0)) $display("FAIL single_pkt_hold: got %h expected %h", bus_pkt, pkt_of(0));
      else pass_cnt++;
   endtask

   task automatic run_seq(input string name, input logic [N-1:0] r, input int exp_g[8],
                          input logic exp_b[8], input int len);
      req = r;
      for (int k = 0; k < len; k++) begin
         #1;
         chk_cnt++;
         if (busy !== exp_b[k]) $display("FAIL %s_busy[%0d]: got %b expected %b", name, k, busy, exp_b[k]);
         else pass_cnt++;
         chk_cnt++;
         if (grant !== (16'h0001 << exp_g[k]))
            $display("FAIL %s_grant[%0d]: got %h expected %h", name, k, grant, 16'h0001 << exp_g[k]);
         else pass_cnt++;
         tick();
         chk_cnt++;
         if (vld !== 1'b1 || bus_pkt !== pkt_of(exp_g[k]))
            $display("FAIL %s_pkt[%0d]: got vld=%b %h expected vld=1 %h", name, k, vld, bus_pkt, pkt_of(exp_g[k]));
         else pass_cnt++;
      end
      req = '0;
   endtask

   task automatic test_round_robin();
      int   eg[8];
      logic eb[8];
      do_reset();
      set_all_weights(4'd1);
      eg = '{0, 1, 4, 0, 1, 4, 0, 0};
      eb = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_seq("rr", 16'h0013, eg, eb, 6);
   endtask

   task automatic test_wrap();
      int   eg[8];
      logic eb[8];
      do_reset();
      set_all_weights(4'd1);
      eg = '{0, 15, 0, 15, 0, 0, 0, 0};
      eb = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_seq("wrap", 16'h8001, eg, eb, 4);
   endtask

   task automatic test_weighted();
      int   eg[8];
      logic eb[8];
      do_reset();
      set_all_weights(4'd1);
      wts[0*WW +: WW] = 4'd3;
      wts[3*WW +: WW] = 4'd2;
`ifdef GBUS_ARB_WEIGHT_EN
      eg = '{0, 0, 0, 3, 3, 0, 0, 0};
      eb = '{0, 1, 1, 0, 1, 0, 1, 1};
      run_seq("wburst", 16'h0009, eg, eb, 8);
      do_reset();
      wts[3*WW +: WW] = 4'd0;
      eg = '{0, 0, 0, 3, 0, 0, 0, 3};
      eb = '{0, 1, 1, 0, 0, 1, 1, 0};
      run_seq("wzero", 16'h0009, eg, eb, 8);
`else
      eg = '{0, 3, 0, 3, 0, 3, 0, 3};
      eb = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_seq("noweight", 16'h0009, eg, eb, 8);
`endif
      set_all_weights(4'd1);
   endtask

`ifdef GBUS_ARB_WEIGHT_EN
   task automatic test_early_end();
      do_reset();
      set_all_weights(4'd1);
      wts[5*WW +: WW] = 4'd4;
      req = 16'h0060;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk_cnt++;
         if (grant !== 16'h0020) $display("FAIL early_owner[%0d]: got %h expected 0020", k, grant);
         else pass_cnt++;
         tick();
      end
      req = 16'h0040;
      #1;
      chk_cnt++;
      if (grant !== 16'h0040) $display("FAIL early_handover: got %h expected 0040", grant); else pass_cnt++;
      tick();
      chk_cnt++;
      if (vld !== 1'b1 || bus_pkt !== pkt_of(6))
         $display("FAIL early_pkt: got vld=%b %h expected vld=1 %h", vld, bus_pkt, pkt_of(6));
      else pass_cnt++;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL early_idle: got %b expected 0", busy); else pass_cnt++;
      req = 16'h0081;
      #1;
      chk_cnt++;
      if (grant !== 16'h0080) $display("FAIL early_ptr7: got %h expected 0080", grant); else pass_cnt++;
      tick();
      req = '0;
      set_all_weights(4'd1);
   endtask
`endif

   task automatic test_reset_mid_burst();
      do_reset();
      set_all_weights(4'd1);
      wts[2*WW +: WW] = 4'd4;
      req = 16'h0004;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk_cnt++;
         if (grant !== 16'h0004) $display("FAIL midrst_grant[%0d]: got %h expected 0004", k, grant);
         else pass_cnt++;
         tick();
      end
`ifdef GBUS_ARB_WEIGHT_EN
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL midrst_busy_pre: got %b expected 1", busy); else pass_cnt++;
`endif
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (vld !== 1'b0 || busy !== 1'b0 || bus_pkt !== '0)
         $display("FAIL midrst_async: got vld=%b busy=%b pkt=%h expected 0/0/0", vld, busy, bus_pkt);
      else pass_cnt++;
      req = 16'h000A;
      #1;
      chk_cnt++;
      if (grant !== 16'h0002) $display("FAIL midrst_grant_rst: got %h expected 0002", grant); else pass_cnt++;
      tick();
      rst_n = 1'b1;
      #1;
      chk_cnt++;
      if (grant !== 16'h0002) $display("FAIL midrst_ptr0: got %h expected 0002", grant); else pass_cnt++;
      tick();
      chk_cnt++;
      if (vld !== 1'b1 || bus_pkt !== pkt_of(1))
         $display("FAIL midrst_first_pkt: got vld=%b %h expected vld=1 %h", vld, bus_pkt, pkt_of(1));
      else pass_cnt++;
      req = '0;
      set_all_weights(4'd1);
   endtask

   initial begin
      for (int i = 0; i < N; i++) pkts[i*PW +: PW] = pkt_of(i);
      set_all_weights(4'd1);
      req   = '0;
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_weighted();
`ifdef GBUS_ARB_WEIGHT_EN
      test_early_end();
`endif
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

`default_nettype wire
